alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter EXIT_DLY, default 16, giving the exit-delay length in clock cycles (legal range 1..65535).
REQ-002 The block SHALL have parameter ENTRY_DLY, default 16, giving the entry-delay length in clock cycles (legal range 1..65535).
REQ-003 The block SHALL have parameter SIREN_TIME, default 64, giving the siren-on length in clock cycles (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, with asynchronous, active-low reset.
REQ-006 The block SHALL have port arm_req, input, 1 bit, a synchronous request to arm, sampled every cycle.
REQ-007 The block SHALL have port disarm_req, input, 1 bit, a synchronous request to disarm, sampled every cycle.
REQ-008 The block SHALL have port vp, input, 1 bit, the asynchronous window/door sensor, where 1 = closed and 0 = open.
REQ-009 The block SHALL have port sm, input, 1 bit, the asynchronous motion sensor, where 1 = motion.
REQ-010 The block SHALL have port armed, output, 1 bit, which is 1 in states ARMED, ENTRY, ALARM and HOLD.
REQ-011 The block SHALL have ports exit_pend and entry_pend, output, 1 bit each, which are 1 in state EXIT and state ENTRY respectively.
REQ-012 The block SHALL have port siren, output, 1 bit, which is 1 only in state ALARM.
REQ-013 The block SHALL have port lights, output, 1 bit, which is 1 in states ALARM and HOLD.
REQ-014 The block SHALL have port event_cnt, output, 8 bits, holding a saturating count of ALARM entries.

Function
REQ-015 vp and sm SHALL each pass through a two-flop synchronizer, producing vp_s and sm_s.
REQ-016 The internal trigger SHALL be defined as trig = ~vp_s | sm_s; trig is evaluated only in states ARMED and HOLD.
REQ-017 The FSM SHALL have the states DISARMED, EXIT, ARMED, ENTRY, ALARM and HOLD.
REQ-018 All outputs SHALL be registered Moore decodes of the state, valid in the cycle the state is entered.
REQ-019 A 16-bit down-counter SHALL be loaded with N-1 on entry to a timed state; the state exits on the edge where the counter equals 0, so the state lasts exactly N cycles.
REQ-020 DISARMED SHALL transition to EXIT when arm_req=1 and disarm_req=0, loading EXIT_DLY-1.
REQ-021 EXIT SHALL transition to ARMED when the count reaches 0; trig SHALL be ignored in EXIT.
REQ-022 ARMED SHALL transition to ENTRY when trig=1, loading ENTRY_DLY-1.
REQ-023 ENTRY SHALL transition to ALARM when the count reaches 0, loading SIREN_TIME-1; sensor return during ENTRY SHALL NOT cancel the transition.
REQ-024 ALARM SHALL transition to HOLD when the count reaches 0.
REQ-025 HOLD SHALL re-enter ALARM when trig=1, reloading SIREN_TIME-1.
REQ-026 event_cnt SHALL increment by 1 on each ALARM entry (from ENTRY or from HOLD) and SHALL saturate at 255, never wrapping.
REQ-027 disarm_req=1 SHALL force DISARMED on the next edge from any state, with priority over arm_req, trig and count expiry.
REQ-028 arm_req SHALL be ignored in every state other than DISARMED.
REQ-029 event_cnt SHALL be preserved across disarm and cleared only by reset.

Reset
REQ-030 While rst_n=0, the state SHALL be DISARMED, the counter 0, the synchronizer flops 1 for vp and 0 for sm, event_cnt 0, and all 1-bit outputs 0, applied immediately without waiting for clk.
REQ-031 Reset assertion mid-operation (including during ALARM) SHALL abort immediately with no residual siren or lights.
REQ-032 The first state change after rst_n deasserts SHALL occur no earlier than the first rising clk edge.

Verification (EXIT_DLY=4, ENTRY_DLY=3, SIREN_TIME=5)
REQ-033 Scenario: arm_req pulse with vp=1, sm=0 -> exit_pend=1 for exactly 4 cycles, then armed=1 and siren=0 held indefinitely.
REQ-034 Scenario: when armed, vp=0 -> entry_pend rises 3 cycles after the vp edge (2 synchronizer cycles + 1), lasts 3 cycles, then siren=1 and lights=1 for 5 cycles, then siren=0 and lights=1, and event_cnt=1.
REQ-035 Scenario: in HOLD, sm=1 -> siren reasserts for 5 cycles and event_cnt=2; then disarm_req -> all outputs 0 next cycle and event_cnt still 2.
REQ-036 Scenario: disarm_req during ENTRY with 1 cycle remaining -> DISARMED, siren never asserts, event_cnt unchanged.
REQ-037 Scenario: arm_req and disarm_req both 1 in DISARMED -> state remains DISARMED; vp=0 during EXIT -> no ENTRY transition.
REQ-038 Scenario: force 256 alarms -> event_cnt=255; rst_n pulse mid-ALARM -> siren=0 asynchronously and event_cnt=0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms after an exit delay, watches a door/window contact
// and a motion sensor, runs an entry delay, then sounds the siren for a fixed
// time before falling back to a lights-only hold state that can re-trigger.
// event_cnt counts siren activations, saturating at 255, cleared only by reset.
module alarm_sequencer #(
  parameter int unsigned EXIT_DLY   = 16,
  parameter int unsigned ENTRY_DLY  = 16,
  parameter int unsigned SIREN_TIME = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       vp,
  input  logic       sm,
  output logic       armed,
  output logic       exit_pend,
  output logic       entry_pend,
  output logic       siren,
  output logic       lights,
  output logic [7:0] event_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  // Counter reload values: a timed state of N cycles starts at N-1 and
  // leaves on the edge where the counter is already 0.
  localparam logic [15:0] EXIT_LOAD  = 16'(EXIT_DLY - 1);
  localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_DLY - 1);
  localparam logic [15:0] SIREN_LOAD = 16'(SIREN_TIME - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        alarm_entry;

  logic        vp_meta;
  logic        vp_s;
  logic        sm_meta;
  logic        sm_s;
  logic        trig;
  logic        cnt_zero;

  // Two-flop synchronizers; reset values model a closed contact and no motion
  // so that leaving reset never looks like an intrusion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_meta <= 1'b1;
      vp_s    <= 1'b1;
      sm_meta <= 1'b0;
      sm_s    <= 1'b0;
    end else begin
      vp_meta <= vp;
      vp_s    <= vp_meta;
      sm_meta <= sm;
      sm_s    <= sm_meta;
    end
  end

  // An open contact or any motion counts as a trigger.
  assign trig     = ~vp_s | sm_s;
  assign cnt_zero = (cnt_q == 16'd0);

  // State and delay-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DISARMED;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; disarm overrides everything else, including expiry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alarm_entry = 1'b0;
    if (disarm_req) begin
      state_d = S_DISARMED;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm_req) begin
            state_d = S_EXIT;
            cnt_d   = EXIT_LOAD;
          end
        end
        S_EXIT: begin
          // Sensors are deliberately ignored so the occupant can leave.
          if (cnt_zero) begin
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_ARMED: begin
          if (trig) begin
            state_d = S_ENTRY;
            cnt_d   = ENTRY_LOAD;
          end
        end
        S_ENTRY: begin
          // Closing the door again does not cancel; only disarm does.
          if (cnt_zero) begin
            state_d     = S_ALARM;
            cnt_d       = SIREN_LOAD;
            alarm_entry = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_ALARM: begin
          if (cnt_zero) begin
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_HOLD: begin
          if (trig) begin
            state_d     = S_ALARM;
            cnt_d       = SIREN_LOAD;
            alarm_entry = 1'b1;
          end
        end
        default: begin
          state_d = S_DISARMED;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Registered Moore outputs decoded from the next state, so they are valid
  // in the same cycle the state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      exit_pend  <= 1'b0;
      entry_pend <= 1'b0;
      siren      <= 1'b0;
      lights     <= 1'b0;
    end else begin
      armed      <= (state_d == S_ARMED) || (state_d == S_ENTRY) ||
                    (state_d == S_ALARM) || (state_d == S_HOLD);
      exit_pend  <= (state_d == S_EXIT);
      entry_pend <= (state_d == S_ENTRY);
      siren      <= (state_d == S_ALARM);
      lights     <= (state_d == S_ALARM) || (state_d == S_HOLD);
    end
  end

  // Saturating count of siren activations; survives disarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= 8'd0;
    end else if (alarm_entry && (event_cnt != 8'hFF)) begin
      event_cnt <= event_cnt + 8'd1;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with EXIT_DLY=4, ENTRY_DLY=3,
// SIREN_TIME=5: a cycle-by-cycle vector table plus hand-written sequences
// for saturation and asynchronous reset.
module tb_alarm_sequencer;

  logic       clk;
  logic       rst_n;
  logic       arm_req;
  logic       disarm_req;
  logic       vp;
  logic       sm;
  logic       armed;
  logic       exit_pend;
  logic       entry_pend;
  logic       siren;
  logic       lights;
  logic [7:0] event_cnt;
  logic [2:0] state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Inputs for one cycle and the outputs expected after the following edge.
  typedef struct {
    logic        arm;
    logic        dis;
    logic        v;
    logic        s;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  alarm_sequencer #(
    .EXIT_DLY  (4),
    .ENTRY_DLY (3),
    .SIREN_TIME(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm_req   (arm_req),
    .disarm_req(disarm_req),
    .vp        (vp),
    .sm        (sm),
    .armed     (armed),
    .exit_pend (exit_pend),
    .entry_pend(entry_pend),
    .siren     (siren),
    .lights    (lights),
    .event_cnt (event_cnt),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] outs;
  assign outs = {armed, exit_pend, entry_pend, siren, lights, event_cnt};

  function automatic logic [12:0] pk(input logic am, input logic ex, input logic en,
                                     input logic si, input logic li, input logic [7:0] ec);
    return {am, ex, en, si, li, ec};
  endfunction

  task automatic add(input logic a, input logic d, input logic v, input logic s,
                     input logic [12:0] e);
    vecs[n_vec] = '{arm: a, dis: d, v: v, s: s, exp: e};
    n_vec++;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // arm dis vp sm | armed exit entry siren lights cnt
    add(0,0,1,0, pk(0,0,0,0,0,0)); // 0 idle
    add(1,1,1,0, pk(0,0,0,0,0,0)); // 1 arm+disarm together: stay disarmed
    add(1,0,1,0, pk(0,1,0,0,0,0)); // 2 exit starts
    add(0,0,0,0, pk(0,1,0,0,0,0)); // 3 door open during exit
    add(0,0,0,0, pk(0,1,0,0,0,0)); // 4
    add(0,0,1,0, pk(0,1,0,0,0,0)); // 5 last exit cycle
    add(0,0,1,0, pk(1,0,0,0,0,0)); // 6 armed, no entry
    add(0,0,1,0, pk(1,0,0,0,0,0)); // 7
    add(1,0,1,0, pk(1,0,0,0,0,0)); // 8 arm ignored while armed
    add(0,0,0,0, pk(1,0,0,0,0,0)); // 9 door opens
    add(0,0,0,0, pk(1,0,0,0,0,0)); // 10
    add(0,0,1,0, pk(1,0,1,0,0,0)); // 11 entry, 3 edges after open
    add(0,0,1,0, pk(1,0,1,0,0,0)); // 12 door closed again, no cancel
    add(0,0,1,0, pk(1,0,1,0,0,0)); // 13
    add(0,0,1,0, pk(1,0,0,1,1,1)); // 14 alarm #1
    for (int i = 0; i < 4; i++) add(0,0,1,0, pk(1,0,0,1,1,1)); // 15..18
    add(0,0,1,0, pk(1,0,0,0,1,1)); // 19 hold
    add(0,0,1,0, pk(1,0,0,0,1,1)); // 20
    add(0,0,1,1, pk(1,0,0,0,1,1)); // 21 motion pulse
    add(0,0,1,0, pk(1,0,0,0,1,1)); // 22
    add(0,0,1,0, pk(1,0,0,1,1,2)); // 23 alarm #2 from hold
    for (int i = 0; i < 4; i++) add(0,0,1,0, pk(1,0,0,1,1,2)); // 24..27
    add(0,0,1,0, pk(1,0,0,0,1,2)); // 28 hold
    add(0,1,1,0, pk(0,0,0,0,0,2)); // 29 disarm, count kept
    add(1,0,1,0, pk(0,1,0,0,0,2)); // 30 re-arm
    for (int i = 0; i < 3; i++) add(0,0,1,0, pk(0,1,0,0,0,2)); // 31..33
    add(0,0,1,0, pk(1,0,0,0,0,2)); // 34 armed
    add(0,0,1,1, pk(1,0,0,0,0,2)); // 35 motion pulse
    add(0,0,1,0, pk(1,0,0,0,0,2)); // 36
    add(0,0,1,0, pk(1,0,1,0,0,2)); // 37 entry
    add(0,0,1,0, pk(1,0,1,0,0,2)); // 38
    add(0,0,1,0, pk(1,0,1,0,0,2)); // 39 last entry cycle
    add(0,1,1,0, pk(0,0,0,0,0,2)); // 40 disarm beats expiry
    add(0,0,1,0, pk(0,0,0,0,0,2)); // 41 siren never came on

    // Reset block
    rst_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; vp = 1'b1; sm = 1'b0;
    #12;
    check("reset_hold", outs, 13'd0);
    repeat (2) @(negedge clk);
    check("reset_after_edges", outs, 13'd0);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < n_vec; i++) begin
      arm_req = vecs[i].arm; disarm_req = vecs[i].dis; vp = vecs[i].v; sm = vecs[i].s;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Saturation: continuous motion re-triggers from hold repeatedly.
    arm_req = 1'b1; disarm_req = 1'b0; vp = 1'b1; sm = 1'b1;
    @(negedge clk);
    arm_req = 1'b0;
    for (int c = 0; c < 3000 && event_cnt != 8'hFF; c++) @(negedge clk);
    check("sat_reached", {5'd0, event_cnt}, {5'd0, 8'hFF});
    repeat (30) @(negedge clk);
    check("sat_no_wrap", {5'd0, event_cnt}, {5'd0, 8'hFF});

    // Asynchronous reset in the middle of an alarm.
    for (int c = 0; c < 20 && siren !== 1'b1; c++) @(negedge clk);
    check("siren_seen", {12'd0, siren}, 13'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs, 13'd0);
    @(negedge clk);
    check("reset_held_alarm", outs, 13'd0);

    // Release between edges with arm pending: nothing moves before an edge.
    sm = 1'b0; arm_req = 1'b1;
    #2 rst_n = 1'b1;
    #1 check("release_no_change", outs, 13'd0);
    @(negedge clk);
    check("first_edge_arm", outs, pk(0,1,0,0,0,0));
    arm_req = 1'b0;
    @(negedge clk);
    check("exit_continues", outs, pk(0,1,0,0,0,0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
